// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel round-robin stream multiplexer with a registered
// output stage (one beat per cycle, one-cycle latency).
// Optional packet lock: define STREAM_MUX_PACKET_LOCK_EN to keep a channel
// granted from its first beat until the beat carrying in_last.
module stream_mux_rr #(
   parameter  int WIDTH = 32,
   parameter  int N     = 4,
   localparam int SW    = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   input  logic [N-1:0]       in_last,
   output logic [N-1:0]       in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SW-1:0]      out_sel,
   output logic               out_last
);

   logic [N-1:0][WIDTH-1:0] ch_data;
   logic [SW-1:0]           ptr;
   logic [SW-1:0]           gnt;
   logic                    gnt_found;
   logic                    load;
   logic                    xfer;

`ifdef STREAM_MUX_PACKET_LOCK_EN
   logic          lock;
   logic [SW-1:0] lock_ch;
`endif

   // unpack the flattened channel bus
   for (genvar i = 0; i < N; i++) begin : g_ch
      assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
   end

   // output register can take a new beat when empty or being drained
   assign load = !out_valid || out_ready;

   // scan ptr, ptr+1, ... wrapping at N (N need not be a power of two)
   always_comb begin
      int idx;
      idx       = 0;
      gnt_found = 1'b0;
      gnt       = '0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!gnt_found && in_valid[idx]) begin
            gnt_found = 1'b1;
            gnt       = SW'(idx);
         end
      end
`ifdef STREAM_MUX_PACKET_LOCK_EN
      // mid-packet: only the owning channel may proceed
      if (lock) begin
         gnt_found = in_valid[lock_ch];
         gnt       = lock_ch;
      end
`endif
   end

   // rst_n gate keeps in_ready low while held in reset
   assign xfer     = gnt_found && load && rst_n;
   assign in_ready = xfer ? (N'(1) << gnt) : '0;

   // output stage and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         out_last  <= 1'b0;
         ptr       <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= ch_data[gnt];
         out_sel   <= gnt;
         out_last  <= in_last[gnt];
`ifdef STREAM_MUX_PACKET_LOCK_EN
         if (in_last[gnt])
            ptr <= (gnt == SW'(N-1)) ? '0 : gnt + 1'b1;
`else
         ptr <= (gnt == SW'(N-1)) ? '0 : gnt + 1'b1;
`endif
      end else if (load) begin
         out_valid <= 1'b0;
      end
   end

`ifdef STREAM_MUX_PACKET_LOCK_EN
   // lock on a beat without last, release on the beat with last
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock    <= 1'b0;
         lock_ch <= '0;
      end else if (xfer) begin
         if (in_last[gnt]) begin
            lock <= 1'b0;
         end else begin
            lock    <= 1'b1;
            lock_ch <= gnt;
         end
      end
   end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: N=4/WIDTH=32 instance for most checks,
// N=3/WIDTH=8 instance for non-power-of-two wrap.
module tb_stream_mux_rr;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] in_data;
   logic [3:0]   in_valid, in_last, in_ready;
   logic [31:0]  out_data;
   logic         out_valid, out_ready, out_last;
   logic [1:0]   out_sel;

   logic [23:0]  in_data3;
   logic [2:0]   in_valid3, in_last3, in_ready3;
   logic [7:0]   out_data3;
   logic         out_valid3, out_ready3, out_last3;
   logic [1:0]   out_sel3;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   stream_mux_rr #(.WIDTH(32), .N(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel),
      .out_last(out_last));

   stream_mux_rr #(.WIDTH(8), .N(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
      .in_last(in_last3), .in_ready(in_ready3), .out_data(out_data3),
      .out_valid(out_valid3), .out_ready(out_ready3), .out_sel(out_sel3),
      .out_last(out_last3));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int i, input logic [31:0] v);
      in_data[i*32 +: 32] = v;
   endtask

   initial begin
      int cnt;
      int exp_sel[5];
      int exp_last[5];
`ifdef STREAM_MUX_PACKET_LOCK_EN
      exp_sel  = '{1, 1, 1, 2, 0};
      exp_last = '{0, 0, 1, 1, 1};
`else
      exp_sel  = '{1, 2, 0, 1, 2};
      exp_last = '{0, 1, 1, 0, 1};
`endif
      rst_n      = 1'b0;
      in_valid   = 4'h0;
      in_last    = 4'hf;
      out_ready  = 1'b1;
      for (int i = 0; i < 4; i++) set_ch(i, 32'h1000_0000 + i);
      in_valid3  = 3'b000;
      in_last3   = 3'b111;
      in_data3   = {8'h32, 8'h31, 8'h30};
      out_ready3 = 1'b1;

      // reset state
      #3;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_sel", out_sel, 0);
      chk("rst_last", out_last, 0);
      in_valid = 4'hf;
      #1;
      chk("rst_in_ready", in_ready, 0);
      #4;
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready", in_ready, 4'b0001);

      // all valid, full throughput rotation
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("rr_sel", out_sel, i % 4);
         chk("rr_valid", out_valid, 1);
         chk("rr_data", out_data, 32'h1000_0000 + (i % 4));
         chk("rr_last", out_last, 1);
      end

      // nothing valid: valid drops, data held
      in_valid = 4'h0;
      tick();
      chk("idle_valid", out_valid, 0);
      chk("idle_data", out_data, 32'h1000_0003);
      chk("idle_sel", out_sel, 3);

      // stall with held output
      in_valid = 4'b0100;
      set_ch(2, 32'hA5A5_A5A5);
      tick();
      chk("st_load_valid", out_valid, 1);
      chk("st_load_data", out_data, 32'hA5A5_A5A5);
      chk("st_load_sel", out_sel, 2);
      out_ready = 1'b0;
      #1;
      chk("st_in_ready0", in_ready, 0);
      for (int s = 0; s < 3; s++) begin
         tick();
         chk("st_data", out_data, 32'hA5A5_A5A5);
         chk("st_valid", out_valid, 1);
         chk("st_in_ready", in_ready, 0);
         if (s == 0) set_ch(2, 32'h5A5A_5A5A);
      end
      out_ready = 1'b1;
      #1;
      chk("st_rel_in_ready", in_ready, 4'b0100);
      tick();
      chk("st_next_data", out_data, 32'h5A5A_5A5A);
      chk("st_next_valid", out_valid, 1);
      in_valid = 4'h0;
      tick();
      chk("st_drain_valid", out_valid, 0);

      // reset while an output is held
      set_ch(2, 32'h1000_0002);
      in_valid = 4'hf;
      tick();
      chk("hr_sel", out_sel, 3);
      chk("hr_valid", out_valid, 1);
      out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("hr_rst_valid", out_valid, 0);
      chk("hr_rst_data", out_data, 0);
      chk("hr_rst_sel", out_sel, 0);
      chk("hr_rst_in_ready", in_ready, 0);
      in_valid  = 4'b1010;
      out_ready = 1'b1;
      #1;
      rst_n = 1'b1;
      #1;
      chk("hr_rel_in_ready", in_ready, 4'b0010);
      tick();
      chk("hr_first_sel", out_sel, 1);
      chk("hr_first_data", out_data, 32'h1000_0001);

      // park pointer at channel 1
      in_valid = 4'b0001;
      tick();
      chk("park_sel", out_sel, 0);

      // ch1 three-beat packet alongside ch0/ch2
      in_valid = 4'b0111;
      in_last  = 4'b1101;
      cnt = 0;
      for (int b = 0; b < 5; b++) begin
         in_last[1] = (cnt == 2);
         tick();
         chk("pkt_sel", out_sel, exp_sel[b]);
         chk("pkt_last", out_last, exp_last[b]);
         chk("pkt_data", out_data, 32'h1000_0000 + exp_sel[b]);
         if (exp_sel[b] == 1) cnt++;
      end
      in_valid = 4'h0;
      in_last  = 4'hf;
      tick();

      // N=3 wrap
      in_valid3 = 3'b111;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("n3_sel", out_sel3, i % 3);
         chk("n3_data", out_data3, 8'h30 + (i % 3));
         chk("n3_valid", out_valid3, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
